// File: rtl/imem_boot_loader.sv
// Boot loader: receives a length-prefixed little-endian byte stream and writes it into imem while holding the CPU in reset.
// Optional NOP fill of the unused words is enabled by defining IMEM_BOOT_NOP_FILL_EN.
module imem_boot_loader #(
  parameter int          DEPTH    = 70,
  parameter int          ADDR_W   = 7,
  parameter logic [31:0] NOP_WORD = 32'h00000013
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              error
);

  localparam int IDX_W = ADDR_W + 1;
  localparam logic [15:0] DEPTH_CNT = 16'(DEPTH);

  localparam logic [2:0] ST_LEN_LO = 3'd0;
  localparam logic [2:0] ST_LEN_HI = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
`ifdef IMEM_BOOT_NOP_FILL_EN
  localparam logic [2:0] ST_FILL   = 3'd3;
  localparam logic [IDX_W-1:0] DEPTH_IDX = IDX_W'(DEPTH);
`endif
  localparam logic [2:0] ST_DONE   = 3'd4;
  localparam logic [2:0] ST_ERR    = 3'd5;

  // Parameter sanity: the address must reach every word and the fill word must be a 32-bit RISC-V encoding.
  if (DEPTH > (1 << ADDR_W)) begin : g_addr_too_narrow
    $error("imem_boot_loader: ADDR_W too small for DEPTH");
  end
  if (NOP_WORD[1:0] != 2'b11) begin : g_bad_nop
    $error("imem_boot_loader: NOP_WORD is not a 32-bit instruction");
  end

  logic [2:0]       state_r;
  logic [2:0]       next_state_s;
  logic [15:0]      count_r;
  logic [15:0]      full_count_s;
  logic [IDX_W-1:0] word_idx_r;
  logic [IDX_W-1:0] word_next_s;
  logic [1:0]       byte_idx_r;
  logic [23:0]      asm_r;
  logic             take_s;
  logic             last_word_s;

  // Next-state decode; word_next_s is the index after the one being written.
  always_comb begin
    take_s       = in_valid && in_ready;
    full_count_s = {in_data, count_r[7:0]};
    word_next_s  = word_idx_r + IDX_W'(1);
    last_word_s  = (16'(word_next_s) == count_r);
    next_state_s = state_r;
    case (state_r)
      ST_LEN_LO: begin
        if (take_s) begin
          next_state_s = ST_LEN_HI;
        end else begin
          next_state_s = ST_LEN_LO;
        end
      end
      ST_LEN_HI: begin
        if (!take_s) begin
          next_state_s = ST_LEN_HI;
        end else if (full_count_s > DEPTH_CNT) begin
          next_state_s = ST_ERR;
        end else if (full_count_s == 16'd0) begin
`ifdef IMEM_BOOT_NOP_FILL_EN
          next_state_s = ST_FILL;
`else
          next_state_s = ST_DONE;
`endif
        end else begin
          next_state_s = ST_DATA;
        end
      end
      ST_DATA: begin
        if (take_s && (byte_idx_r == 2'd3) && last_word_s) begin
`ifdef IMEM_BOOT_NOP_FILL_EN
          // FILL is skipped when nothing is left to pad, so done still follows the last write by one cycle.
          if (word_next_s < DEPTH_IDX) begin
            next_state_s = ST_FILL;
          end else begin
            next_state_s = ST_DONE;
          end
`else
          next_state_s = ST_DONE;
`endif
        end else begin
          next_state_s = ST_DATA;
        end
      end
`ifdef IMEM_BOOT_NOP_FILL_EN
      ST_FILL: begin
        if (word_next_s == DEPTH_IDX) begin
          next_state_s = ST_DONE;
        end else begin
          next_state_s = ST_FILL;
        end
      end
`endif
      ST_DONE: next_state_s = ST_DONE;
      ST_ERR:  next_state_s = ST_ERR;
      default: next_state_s = ST_LEN_LO;
    endcase
  end

  // State, byte assembly, imem write port and status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_LEN_LO;
      count_r    <= 16'd0;
      word_idx_r <= '0;
      byte_idx_r <= 2'd0;
      asm_r      <= 24'd0;
      in_ready   <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= 32'd0;
      cpu_rst    <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      state_r  <= next_state_s;
      in_ready <= (next_state_s == ST_LEN_LO) || (next_state_s == ST_LEN_HI) ||
                  (next_state_s == ST_DATA);
      imem_we  <= 1'b0;
      case (state_r)
        ST_LEN_LO: begin
          if (take_s) begin
            count_r[7:0] <= in_data;
          end
        end
        ST_LEN_HI: begin
          if (take_s) begin
            count_r[15:8] <= in_data;
            word_idx_r    <= '0;
            byte_idx_r    <= 2'd0;
            if (full_count_s > DEPTH_CNT) begin
              error <= 1'b1;
            end
          end
        end
        ST_DATA: begin
          if (take_s) begin
            byte_idx_r <= byte_idx_r + 2'd1;
            case (byte_idx_r)
              2'd0: asm_r[7:0]   <= in_data;
              2'd1: asm_r[15:8]  <= in_data;
              2'd2: asm_r[23:16] <= in_data;
              default: begin
                imem_we    <= 1'b1;
                imem_addr  <= word_idx_r[ADDR_W-1:0];
                imem_wdata <= {in_data, asm_r};
                word_idx_r <= word_next_s;
              end
            endcase
          end
        end
`ifdef IMEM_BOOT_NOP_FILL_EN
        ST_FILL: begin
          imem_we    <= 1'b1;
          imem_addr  <= word_idx_r[ADDR_W-1:0];
          imem_wdata <= NOP_WORD;
          word_idx_r <= word_next_s;
        end
`endif
        ST_DONE: begin
          done    <= 1'b1;
          cpu_rst <= 1'b0;
        end
        ST_ERR: begin
          error   <= 1'b1;
          cpu_rst <= 1'b1;
        end
        default: begin
          cpu_rst <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Randomized bench for imem_boot_loader: streams are checked against a write list derived from the stream format.
module tb_imem_boot_loader;
  localparam int DEPTH = 70;
  localparam int ADDR_W = 7;
  localparam logic [31:0] NOP = 32'h00000013;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = 8'd0;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_rst;
  logic              done;
  logic              error;

  imem_boot_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .NOP_WORD(NOP)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_rst(cpu_rst), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  logic [7:0]  stream[$];
  int          exp_addr[$];
  logic [31:0] exp_data[$];
  int          n_words;
  logic        exp_done;
  logic        exp_err;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: derive the expected imem write list straight from the stream format.
  task automatic build_expect();
    int n;
    n = int'({stream[1], stream[0]});
    exp_addr.delete();
    exp_data.delete();
    n_words = 0;
    if (n > DEPTH) begin
      exp_err  = 1'b1;
      exp_done = 1'b0;
    end else begin
      exp_err  = 1'b0;
      exp_done = 1'b1;
      n_words  = n;
      for (int i = 0; i < n; i++) begin
        exp_addr.push_back(i);
        exp_data.push_back({stream[4*i+5], stream[4*i+4], stream[4*i+3], stream[4*i+2]});
      end
`ifdef IMEM_BOOT_NOP_FILL_EN
      for (int a = n; a < DEPTH; a++) begin
        exp_addr.push_back(a);
        exp_data.push_back(NOP);
      end
`endif
    end
  endtask

  task automatic do_reset(input string name);
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_eq({name, ":rst_in_ready"}, 32'(in_ready), 32'd0);
    check_eq({name, ":rst_we"}, 32'(imem_we), 32'd0);
    check_eq({name, ":rst_addr"}, 32'(imem_addr), 32'd0);
    check_eq({name, ":rst_wdata"}, imem_wdata, 32'd0);
    check_eq({name, ":rst_cpu_rst"}, 32'(cpu_rst), 32'd1);
    check_eq({name, ":rst_done"}, 32'(done), 32'd0);
    check_eq({name, ":rst_error"}, 32'(error), 32'd0);
    @(negedge clk);
    #2 rst = 1'b0;
  endtask

  task automatic feed_partial();
    int idx = 0;
    do_reset("partial");
    for (int k = 0; k < 40 && idx < stream.size(); k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = stream[idx];
      if (in_ready) idx++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    check_eq("partial:accepted", idx, stream.size());
  endtask

  // mode 0: valid held high, 1: valid toggles every cycle, 2: random valid.
  task automatic run_load(input string name, input int mode);
    int got_addr[$];
    logic [31:0] got_data[$];
    int got_cyc[$];
    int acc_cyc[$];
    int idx = 0;
    int done_cyc = -1;
    int rel_cyc = -1;
    int tail = 0;
    logic v;
    int nchk;
    build_expect();
    do_reset(name);
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      cyc++;
      if (imem_we) begin
        got_addr.push_back(int'(imem_addr));
        got_data.push_back(imem_wdata);
        got_cyc.push_back(cyc);
      end
      if (done && done_cyc < 0) done_cyc = cyc;
      if (!cpu_rst && rel_cyc < 0) rel_cyc = cyc;
      if (done || error) tail++;
      if (tail > 100) break;
      case (mode)
        0: v = 1'b1;
        1: v = (cyc % 2) == 0;
        default: v = ($urandom_range(0, 1) == 1);
      endcase
      v = v && (idx < stream.size());
      in_valid = v;
      in_data  = v ? stream[idx] : 8'($urandom);
      if (v && in_ready) begin
        acc_cyc.push_back(cyc);
        idx++;
      end
    end
    in_valid = 1'b0;
    check_eq({name, ":finished"}, 32'(tail > 100), 32'd1);
    check_eq({name, ":error"}, 32'(error), 32'(exp_err));
    check_eq({name, ":done"}, 32'(done), 32'(exp_done));
    check_eq({name, ":cpu_rst"}, 32'(cpu_rst), 32'(!exp_done));
    check_eq({name, ":in_ready_end"}, 32'(in_ready), 32'd0);
    check_eq({name, ":nwrites"}, got_addr.size(), exp_addr.size());
    nchk = (got_addr.size() < exp_addr.size()) ? got_addr.size() : exp_addr.size();
    for (int i = 0; i < nchk; i++) begin
      check_eq($sformatf("%s:addr%0d", name, i), got_addr[i], exp_addr[i]);
      check_eq($sformatf("%s:data%0d", name, i), got_data[i], exp_data[i]);
    end
    for (int j = 0; j < n_words; j++) begin
      if (j < got_cyc.size() && (4*j+5) < acc_cyc.size())
        check_eq($sformatf("%s:lat%0d", name, j), got_cyc[j], acc_cyc[4*j+5] + 1);
    end
    if (exp_done) begin
      if (got_cyc.size() > 0)
        check_eq({name, ":done_lat"}, done_cyc, got_cyc[got_cyc.size()-1] + 1);
      else if (acc_cyc.size() >= 2)
        check_eq({name, ":done_lat0"}, done_cyc, acc_cyc[1] + 2);
      else
        check_eq({name, ":len_accepted"}, acc_cyc.size(), 2);
      check_eq({name, ":release"}, rel_cyc, done_cyc);
    end else begin
      check_eq({name, ":no_release"}, rel_cyc, -1);
      check_eq({name, ":no_done"}, done_cyc, -1);
    end
  endtask

  task automatic rand_stream(input int n, input int extra);
    stream.delete();
    stream.push_back(8'(n));
    stream.push_back(8'(n >> 8));
    for (int i = 0; i < 4*n + extra; i++) stream.push_back(8'($urandom));
  endtask

  initial begin
    stream = '{8'h03, 8'h00, 8'h93, 8'h00, 8'hA0, 8'h00, 8'h13, 8'h01, 8'h30, 8'h00,
               8'hB3, 8'h81, 8'h20, 8'h00};
    run_load("basic", 0);
    run_load("backpressure", 1);

    stream = '{8'h00, 8'h00};
    run_load("zero", 2);

    stream = '{8'h47, 8'h00};
    run_load("overflow", 2);

    stream = '{8'h02, 8'h00, 8'h11, 8'h22};
    feed_partial();
    stream = '{8'h01, 8'h00, 8'hB3, 8'hE3, 8'h20, 8'h00};
    run_load("rst_mid_word", 2);
    check_eq("rst_mid_word:model", exp_data[0], 32'h0020e3b3);

    rand_stream(DEPTH, 0);
    run_load("full_depth", 2);

    for (int r = 0; r < 3; r++) begin
      rand_stream($urandom_range(1, DEPTH), 0);
      run_load($sformatf("rand%0d", r), 2);
    end

    rand_stream(0, 0);
    stream[0] = 8'($urandom_range(0, 255));
    stream[1] = 8'($urandom_range(1, 255));
    for (int i = 0; i < 6; i++) stream.push_back(8'($urandom));
    run_load("rand_overflow", 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
